mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the Execute stage, directly upstream of the Memory stage.
- Holds the architectural HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU over a fixed number of cycles and services MTHI/MTLO writes.
- Supplies the MFHI/MFLO read value, which Execute muxes into ALUoutE; that value travels to ALUoutM1.
- Raises a stall request so the hazard unit freezes F/D while the unit is busy.

---
 rtl/mdu_unit.sv | 130 +++++++++++++
 tb/tb_mdu_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit - multi-cycle multiply/divide unit holding the HI/LO registers.
//
// MULT/MULTU/DIV/DIVU compute their result at the launch edge into shadow
// registers. A down-counter then holds Busy for a fixed latency. When it
// expires, the shadow result is committed to HI/LO. MTHI/MTLO write
// directly when idle. Any Start seen while Busy is ignored.
//
// Optional build macro MDU_MADD_EN: MDop 6/7 become MADD/MADDU. These
// accumulate a signed/unsigned product into {HI,LO} with MULT latency.
// Without the macro, MDop 6/7 are no-ops.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous reset, active low
//   Start     launch/write request for MDop (sampled on clk rise)
//   MDop      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 see above
//   A, B      rs / rt operands
//   HIsel     MDout select: 1 = HI, 0 = LO
//   Busy      registered, high while an operation is in flight
//   StallReq  Busy, or a long op being requested this cycle
//   MDout     HIsel ? HI : LO (register contents only, no bypass)
//   HI, LO    architectural HI/LO registers
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIsel,
    output logic        Busy,
    output logic        StallReq,
    output logic [31:0] MDout,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [31:0]   hiReg, loReg;
    logic [63:0]   shadow;
    logic          commitEn;
    logic          busyReg;
    logic [CW-1:0] cnt;

    logic          isLong, isDiv, signedDiv, divByZero;
    logic [63:0]   prodS, prodU, result;
    logic [31:0]   divisor, dA, dB, uq, ur, quo, rem;
    logic [CW-1:0] loadCnt;

    always_comb begin
        isDiv     = (MDop == 3'd2) || (MDop == 3'd3);
        signedDiv = (MDop == 3'd2);
        divByZero = isDiv && (B == 32'd0);
`ifdef MDU_MADD_EN
        isLong    = (MDop != 3'd4) && (MDop != 3'd5);
`else
        isLong    = (MDop <= 3'd3);
`endif
        loadCnt   = isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

        prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU = {32'd0, A} * {32'd0, B};

        // Signed divide is done on magnitudes, so 0x80000000 / -1 falls out
        // naturally as quotient 0x80000000, remainder 0. A zero divisor is
        // replaced by 1 to keep the divider defined; the result is discarded.
        divisor = (B == 32'd0) ? 32'd1 : B;
        dA  = (signedDiv && A[31])       ? (~A + 32'd1)       : A;
        dB  = (signedDiv && divisor[31]) ? (~divisor + 32'd1) : divisor;
        uq  = dA / dB;
        ur  = dA % dB;
        quo = (signedDiv && (A[31] ^ divisor[31])) ? (~uq + 32'd1) : uq;
        rem = (signedDiv && A[31])                 ? (~ur + 32'd1) : ur;

        case (MDop)
            3'd0:    result = prodS;
            3'd1:    result = prodU;
            3'd2,
            3'd3:    result = {rem, quo};
`ifdef MDU_MADD_EN
            // Accumulate base is HI/LO as they stand at the launch edge.
            3'd6:    result = {hiReg, loReg} + prodS;
            3'd7:    result = {hiReg, loReg} + prodU;
`endif
            default: result = {hiReg, loReg};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hiReg    <= 32'd0;
            loReg    <= 32'd0;
            shadow   <= 64'd0;
            commitEn <= 1'b0;
            busyReg  <= 1'b0;
            cnt      <= '0;
        end else if (busyReg) begin
            // Starts are dropped while busy; only the countdown advances.
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busyReg <= 1'b0;
                if (commitEn) begin
                    hiReg <= shadow[63:32];
                    loReg <= shadow[31:0];
                end
            end
        end else if (Start) begin
            if (isLong) begin
                shadow   <= result;
                commitEn <= !divByZero;
                cnt      <= loadCnt;
                busyReg  <= 1'b1;
            end else if (MDop == 3'd4) begin
                hiReg <= A;
            end else if (MDop == 3'd5) begin
                loReg <= A;
            end
        end
    end

    assign Busy     = busyReg;
    assign StallReq = busyReg | (Start & isLong);
    assign MDout    = HIsel ? hiReg : loReg;
    assign HI       = hiReg;
    assign LO       = loReg;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (default 5/10 cycle latencies).
// Compile with +define+MDU_MADD_EN to exercise the MADD/MADDU path.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDop;
    logic [31:0] A, B;
    logic        HIsel;
    logic        Busy, StallReq;
    logic [31:0] MDout, HI, LO;

    int errs   = 0;
    int checks = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDop(MDop), .A(A), .B(B),
        .HIsel(HIsel), .Busy(Busy), .StallReq(StallReq), .MDout(MDout),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a long op for one cycle and count how many sampled cycles Busy stays high.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        Start = 1'b1; MDop = op; A = a; B = b;
        tick();
        Start = 1'b0;
        n = 0;
        while (Busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic write(input logic [2:0] op, input logic [31:0] a);
        Start = 1'b1; MDop = op; A = a;
        tick();
        Start = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b0; Start = 1'b0; MDop = 3'd0; A = '0; B = '0; HIsel = 1'b0;
        #2;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // MULT -2 * 3
        Start = 1'b1; MDop = 3'd0; A = 32'hFFFFFFFE; B = 32'd3; #1;
        chk("mult_stallreq_comb", 32'(StallReq), 32'd1);
        tick();
        Start = 1'b0;
        chk("mult_busy_launch", 32'(Busy), 32'd1);
        chk("mult_no_bypass", HI, 32'd0);
        n = 1;
        while (Busy && n < 50) begin tick(); if (Busy) n++; end
        chk("mult_latency", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        runOp(3'd1, 32'hFFFFFFFE, 32'd3, n);
        chk("multu_latency", n, 32'd5);
        chk("multu_hi", HI, 32'h00000002);
        chk("multu_lo", LO, 32'hFFFFFFFA);

        runOp(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("mult_negneg_hi", HI, 32'd0);
        chk("mult_negneg_lo", LO, 32'd1);

        // DIV -7 / 2
        runOp(3'd2, 32'hFFFFFFF9, 32'd2, n);
        chk("div_latency", n, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        // DIVU by zero: full latency, no update
        runOp(3'd3, 32'd7, 32'd0, n);
        chk("divz_latency", n, 32'd10);
        chk("divz_lo", LO, 32'hFFFFFFFD);
        chk("divz_hi", HI, 32'hFFFFFFFF);

        runOp(3'd2, 32'd7, 32'hFFFFFFFE, n);
        chk("div_negdiv_lo", LO, 32'hFFFFFFFD);
        chk("div_negdiv_hi", HI, 32'd1);

        runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'd0);

        runOp(3'd3, 32'hFFFFFFF9, 32'd2, n);
        chk("divu_lo", LO, 32'h7FFFFFFC);
        chk("divu_hi", HI, 32'd1);

        // MTHI then MTLO back to back
        Start = 1'b1; MDop = 3'd4; A = 32'h12345678; #1;
        chk("mthi_stallreq", 32'(StallReq), 32'd0);
        tick();
        chk("mthi_busy", 32'(Busy), 32'd0);
        MDop = 3'd5; A = 32'h9ABCDEF0;
        tick();
        Start = 1'b0;
        chk("mtlo_busy", 32'(Busy), 32'd0);
        HIsel = 1'b1; #1;
        chk("mfhi", MDout, 32'h12345678);
        HIsel = 1'b0; #1;
        chk("mflo", MDout, 32'h9ABCDEF0);

        // MTLO while MULT is busy is dropped
        Start = 1'b1; MDop = 3'd0; A = 32'h00010000; B = 32'h00010000;
        tick();
        MDop = 3'd5; A = 32'hDEADBEEF;
        n = 0;
        while (Busy && n < 50) begin
            chk("busy_stallreq", 32'(StallReq), 32'd1);
            n++;
            tick();
        end
        Start = 1'b0;
        chk("mtlo_busy_latency", n, 32'd5);
        chk("mtlo_busy_lo", LO, 32'd0);
        chk("mtlo_busy_hi", HI, 32'd1);

        // Reset during cycle 3 of a DIV
        Start = 1'b1; MDop = 3'd2; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0;
        tick(); tick();
        reset = 1'b0; #1;
        chk("rstmid_busy", 32'(Busy), 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("rstmid_after_hi", HI, 32'd0);
        chk("rstmid_after_lo", LO, 32'd0);
        chk("rstmid_after_busy", 32'(Busy), 32'd0);

        // MADDU / reserved opcode
        write(3'd4, 32'd0);
        write(3'd5, 32'hFFFFFFFF);
        Start = 1'b1; MDop = 3'd7; A = 32'd1; B = 32'd1; #1;
`ifdef MDU_MADD_EN
        chk("maddu_stallreq", 32'(StallReq), 32'd1);
        tick();
        Start = 1'b0;
        n = 1;
        while (Busy && n < 50) begin tick(); if (Busy) n++; end
        chk("maddu_latency", n, 32'd5);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
        runOp(3'd6, 32'hFFFFFFFF, 32'd2, n);
        chk("madd_hi", HI, 32'd0);
        chk("madd_lo", LO, 32'hFFFFFFFE);
`else
        chk("op7_stallreq", 32'(StallReq), 32'd0);
        tick();
        MDop = 3'd6; #1;
        chk("op6_stallreq", 32'(StallReq), 32'd0);
        tick();
        Start = 1'b0;
        chk("op67_busy", 32'(Busy), 32'd0);
        chk("op67_hi", HI, 32'd0);
        chk("op67_lo", LO, 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
